uart_receiver_param: RTL and testbench
======================================

Name: uart_receiver_param

Overview:
Parametrised successor to the team's fixed 8N1 serial-to-parallel receiver.
- Generalised in data width, parity mode, stop-bit count and oversampling ratio.
- Samples mid-bit and rejects start-bit glitches.
- Reports framing, parity and overrun errors.
- Presents each word on a valid/ready output handshake to the downstream consumer (register file or FIFO).

Parameters:
- DATA_BITS, 8, payload bits per frame; legal range 5..9; sent LSB first.
- OVERSAMPLE, 16, baud_rate_signal ticks per bit period; even; legal range 4..32.
- PARITY_MODE, 0, parity: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_rx  input  1  serial line; idles high.
- baud_rate_signal  input  1  one-clk strobe at OVERSAMPLE x baud.
- data  output  DATA_BITS  received word; stable while valid_data=1.
- valid_data  output  1  word available; held until accepted.
- data_ready  input  1  consumer accepts the word when valid_data && data_ready.
- frame_err  output  1  a stop bit sampled 0; qualified by valid_data.
- parity_err  output  1  parity mismatch; always 0 when PARITY_MODE=0; qualified by valid_data.
- overrun  output  1  sticky; set when a frame completes while valid_data=1 and is not accepted that cycle.

Behaviour:
- Reset (synchronous, active-high) forces all state and outputs to 0, including data, valid_data, frame_err, parity_err and overrun. The FSM goes to IDLE.
- Reset overrides everything, including a frame in flight. The partial frame is discarded.
- The tick counter (width clog2(OVERSAMPLE)) and bit counter (width clog2(DATA_BITS+1)) advance only on baud_rate_signal=1. They hold otherwise.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: on a tick with uart_rx=0, go to START and clear the tick counter.
- START: after OVERSAMPLE/2 ticks, re-sample uart_rx.
  - If 1: glitch; return to IDLE, no output.
  - If 0: clear the tick counter and go to DATA.
- DATA: sample every OVERSAMPLE ticks (bit centre). Shift the sample into the MSB of the shift register, LSB-first.
  - After DATA_BITS samples, go to PARITY if PARITY_MODE != 0, else STOP.
- PARITY: sample one bit and compare it with the XOR of the data bits.
  - Even mode: the XOR of data plus parity bit must be 0.
  - Odd mode: it must be 1.
  - Mismatch latches an internal parity error.
- STOP: sample STOP_BITS bits, each at its bit centre. Any 0 latches an internal frame error.
- STOP exit, on the clk after the centre of the last stop bit:
  - data, frame_err and parity_err load together; valid_data goes to 1.
  - The FSM returns to IDLE immediately. It does not wait for the end of the stop bit.
- On a frame error, the FSM also returns to IDLE. A line held low then re-triggers START on the next tick (break appears as repeated frame errors).
- Handshake:
  - valid_data falls the clk after valid_data && data_ready. data, frame_err and parity_err are held until then.
  - If a new frame completes in the same cycle as acceptance, the new word loads and valid_data stays 1. No overrun.
  - If a new frame completes while valid_data=1 and data_ready=0, the new word is dropped, the old word is kept and overrun is set.
  - overrun clears only on reset.
- Latency (OVERSAMPLE=16, 8N1): valid_data rises about 9.5 bit periods (152 ticks) after the tick that detects the start edge.
- baud_rate_signal asserted on consecutive clks is legal; each assertion counts as one tick.

Optional Feature:
- Macro UART_RX_SYNC_EN.
- Defined: uart_rx passes through a 2-flop synchroniser, reset to 1, before the FSM. All latencies increase by 2 clk cycles.
- Undefined: uart_rx drives the FSM directly; the line must already be synchronous to clk.
- Behaviour is otherwise identical.

Decomposition:
- Shared package uart_pkg holds:
  - the rx state enum (IDLE/START/DATA/PARITY/STOP);
  - parity-mode constants PARITY_NONE/EVEN/ODD;
  - a parity function returning the XOR reduction of a vector.
- One natural sub-module, uart_rx_sync: the 2-flop synchroniser, instantiated only under UART_RX_SYNC_EN.

Test Plan:
- Defaults (8N1, OVERSAMPLE=16), data_ready=1, send 0xA5 -> data=0xA5, valid_data high exactly 1 clk, frame_err=0, parity_err=0.
- PARITY_MODE=1, send 0x07 with parity bit 0 -> data=0x07, parity_err=1. Resend with parity bit 1 -> parity_err=0.
- Low pulse of 4 ticks on uart_rx in IDLE -> no valid_data; a following 0x3C frame is received correctly.
- STOP_BITS=2, send 0x55 with second stop bit 0 -> data=0x55, frame_err=1, valid_data=1.
- data_ready=0, send 0x11 then 0x22 -> data stays 0x11, overrun=1. Assert data_ready -> valid_data falls next clk, overrun stays 1 until reset.
- Assert reset mid-DATA of 0x81, release, send 0x42 -> only 0x42 delivered; all outputs 0 during reset.

Source files
------------

// File: rtl/uart_pkg.sv
// Purpose : shared types and helpers for the parametrised UART receiver.
// Contents: rx FSM state enum, parity-mode constants, XOR-reduction helper.
// Ports   : none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // XOR reduction of a payload; narrower words are zero-extended by the caller.
  function automatic logic parity_of(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Purpose : 2-flop synchroniser for the asynchronous serial line.
// Latency : 2 clk; no backpressure (free-running).
// Ports   : clk, reset (sync, active-high, resets to line-idle 1), din (async line), dout (synchronised line).
// Only compiled into the build when UART_RX_SYNC_EN is defined.
`ifdef UART_RX_SYNC_EN
module uart_rx_sync (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  logic meta;

  // Reset to 1 so the FSM sees an idle line rather than a false start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b1;
      dout <= 1'b1;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule
`endif

// File: rtl/uart_receiver_param.sv
// Purpose : parametrised serial-to-parallel UART receiver (data width, parity, stop bits, oversampling).
// Latency : word presented the clk after the centre of the last stop bit (~9.5 bit periods for 8N1); +2 clk with UART_RX_SYNC_EN.
// Backpressure: word held on valid_data until data_ready; a frame completing while a word is still pending is dropped and sets sticky overrun.
// Ports   : clk, reset (sync, active-high), uart_rx (serial in, idles high), baud_rate_signal (OVERSAMPLE x baud strobe),
//           data/valid_data/data_ready (output handshake), frame_err/parity_err (qualified by valid_data), overrun (sticky).
// Macro   : UART_RX_SYNC_EN inserts a 2-flop synchroniser on uart_rx; undefined means uart_rx is already synchronous to clk.
module uart_receiver_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 uart_rx,
  input  logic                 baud_rate_signal,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid_data,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  logic rx;

`ifdef UART_RX_SYNC_EN
  uart_rx_sync u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .din   (uart_rx),
    .dout  (rx)
  );
`else
  assign rx = uart_rx;
`endif

  rx_state_t            state;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bad;
  logic                 frm_bad;

  // Centre of the current bit: the OVERSAMPLE-th tick since the previous centre.
  logic at_centre;
  assign at_centre = baud_rate_signal && (tick_cnt == BIT_LAST);

  // Parity mismatch against the fully shifted payload and the sampled parity bit.
  logic par_mis;
  always_comb begin
    par_mis = parity_of(32'(shift)) ^ rx;
    if (PARITY_MODE == PARITY_ODD) par_mis = ~par_mis;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      par_bad    <= 1'b0;
      frm_bad    <= 1'b0;
      data       <= '0;
      valid_data <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Acceptance; a frame completing this same cycle overrides it below.
      if (valid_data && data_ready) valid_data <= 1'b0;

      case (state)
        IDLE: begin
          if (baud_rate_signal && !rx) begin
            state    <= START;
            tick_cnt <= '0;
          end
        end

        START: begin
          if (baud_rate_signal) begin
            if (tick_cnt == HALF_LAST) begin
              // Mid start bit: a high line means the edge was a glitch.
              tick_cnt <= '0;
              bit_cnt  <= '0;
              par_bad  <= 1'b0;
              frm_bad  <= 1'b0;
              state    <= rx ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
        end

        DATA: begin
          if (at_centre) begin
            tick_cnt <= '0;
            shift    <= {rx, shift[DATA_BITS-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (baud_rate_signal) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (at_centre) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            par_bad  <= par_mis;
            state    <= STOP;
          end else if (baud_rate_signal) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        STOP: begin
          if (at_centre) begin
            tick_cnt <= '0;
            if (!rx) frm_bad <= 1'b1;
            if (bit_cnt == STOP_LAST) begin
              // Leave at the centre of the last stop bit so a held-low line re-triggers at once.
              state   <= IDLE;
              bit_cnt <= '0;
              if (!valid_data || data_ready) begin
                data       <= shift;
                frame_err  <= frm_bad | ~rx;
                parity_err <= par_bad;
                valid_data <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (baud_rate_signal) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver_param.sv
// Purpose : directed self-checking bench for uart_receiver_param.
// Instances: [0] defaults 8N1, [1] even parity, [2] two stop bits; baud strobe every other clk.
module tb_uart_receiver_param;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            baud = 1'b0;
  logic [2:0]      rx_line = 3'b111;
  logic [2:0]      rdy = 3'b111;
  logic [2:0][7:0] dout;
  logic [2:0]      vld;
  logic [2:0]      fe;
  logic [2:0]      pe;
  logic [2:0]      ovr;

  int total = 0;
  int bad = 0;

  // Monitor state: cycles with valid_data high and the last word seen per instance.
  int         vcyc [3];
  logic [7:0] cap_d [3];
  logic       cap_fe [3];
  logic       cap_pe [3];

  always #5 clk = ~clk;
  // Strobe changes on the falling edge so it is stable at every rising edge.
  always @(negedge clk) baud = ~baud;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (vld[i] === 1'b1) begin
        vcyc[i]   = vcyc[i] + 1;
        cap_d[i]  = dout[i];
        cap_fe[i] = fe[i];
        cap_pe[i] = pe[i];
      end
    end
  end

  uart_receiver_param dut_8n1 (
    .clk(clk), .reset(reset), .uart_rx(rx_line[0]), .baud_rate_signal(baud),
    .data(dout[0]), .valid_data(vld[0]), .data_ready(rdy[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0])
  );

  uart_receiver_param #(.PARITY_MODE(1)) dut_par (
    .clk(clk), .reset(reset), .uart_rx(rx_line[1]), .baud_rate_signal(baud),
    .data(dout[1]), .valid_data(vld[1]), .data_ready(rdy[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ovr[1])
  );

  uart_receiver_param #(.STOP_BITS(2)) dut_s2 (
    .clk(clk), .reset(reset), .uart_rx(rx_line[2]), .baud_rate_signal(baud),
    .data(dout[2]), .valid_data(vld[2]), .data_ready(rdy[2]),
    .frame_err(fe[2]), .parity_err(pe[2]), .overrun(ovr[2])
  );

  // Consume n baud ticks, then step 1 time unit past the last tick edge.
  task automatic wait_ticks(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      while (baud !== 1'b1) @(posedge clk);
    end
    #1;
  endtask

  // Drive bits[0..n-1] onto one line, 16 ticks each, then return the line to idle.
  task automatic send_bits(input int idx, input logic [15:0] bits, input int n);
    for (int b = 0; b < n; b++) begin
      rx_line[idx] = bits[b];
      wait_ticks(16);
    end
    rx_line[idx] = 1'b1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      total++; if (vld[i] !== 1'b0) begin bad++; $display("FAIL reset_valid[%0d] got=%b want=0", i, vld[i]); end
      total++; if (dout[i] !== 8'h00) begin bad++; $display("FAIL reset_data[%0d] got=%h want=00", i, dout[i]); end
      total++; if ({fe[i], pe[i], ovr[i]} !== 3'b000) begin bad++; $display("FAIL reset_flags[%0d] got=%b want=000", i, {fe[i], pe[i], ovr[i]}); end
    end
    reset = 1'b0;
    wait_ticks(4);
  endtask

  task automatic test_basic;
    int v0;
    v0 = vcyc[0];
    send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    wait_ticks(4);
    total++; if (vcyc[0] - v0 !== 1) begin bad++; $display("FAIL basic_valid_cycles got=%0d want=1", vcyc[0] - v0); end
    total++; if (cap_d[0] !== 8'hA5) begin bad++; $display("FAIL basic_data got=%h want=a5", cap_d[0]); end
    total++; if (cap_fe[0] !== 1'b0) begin bad++; $display("FAIL basic_frame_err got=%b want=0", cap_fe[0]); end
    total++; if (cap_pe[0] !== 1'b0) begin bad++; $display("FAIL basic_parity_err got=%b want=0", cap_pe[0]); end
  endtask

  task automatic test_parity;
    int v0;
    // 0x07 has three ones: even parity needs parity bit 1.
    v0 = vcyc[1];
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    wait_ticks(4);
    total++; if (vcyc[1] - v0 !== 1) begin bad++; $display("FAIL parity_bad_count got=%0d want=1", vcyc[1] - v0); end
    total++; if (cap_d[1] !== 8'h07) begin bad++; $display("FAIL parity_bad_data got=%h want=07", cap_d[1]); end
    total++; if (cap_pe[1] !== 1'b1) begin bad++; $display("FAIL parity_bad_flag got=%b want=1", cap_pe[1]); end
    v0 = vcyc[1];
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    wait_ticks(4);
    total++; if (vcyc[1] - v0 !== 1) begin bad++; $display("FAIL parity_ok_count got=%0d want=1", vcyc[1] - v0); end
    total++; if (cap_pe[1] !== 1'b0) begin bad++; $display("FAIL parity_ok_flag got=%b want=0", cap_pe[1]); end
    total++; if (cap_fe[1] !== 1'b0) begin bad++; $display("FAIL parity_ok_frame got=%b want=0", cap_fe[1]); end
  endtask

  task automatic test_glitch;
    int v0;
    v0 = vcyc[0];
    rx_line[0] = 1'b0;
    wait_ticks(4);
    rx_line[0] = 1'b1;
    wait_ticks(24);
    total++; if (vcyc[0] - v0 !== 0) begin bad++; $display("FAIL glitch_no_word got=%0d want=0", vcyc[0] - v0); end
    send_bits(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    wait_ticks(4);
    total++; if (vcyc[0] - v0 !== 1) begin bad++; $display("FAIL glitch_follow_count got=%0d want=1", vcyc[0] - v0); end
    total++; if (cap_d[0] !== 8'h3C) begin bad++; $display("FAIL glitch_follow_data got=%h want=3c", cap_d[0]); end
  endtask

  task automatic test_stop2;
    int v0;
    v0 = vcyc[2];
    // Second stop bit low; the trailing low re-triggers START but is rejected as a glitch.
    send_bits(2, {5'b0, 1'b0, 1'b1, 8'h55, 1'b0}, 11);
    wait_ticks(24);
    total++; if (vcyc[2] - v0 !== 1) begin bad++; $display("FAIL stop2_count got=%0d want=1", vcyc[2] - v0); end
    total++; if (cap_d[2] !== 8'h55) begin bad++; $display("FAIL stop2_data got=%h want=55", cap_d[2]); end
    total++; if (cap_fe[2] !== 1'b1) begin bad++; $display("FAIL stop2_frame_err got=%b want=1", cap_fe[2]); end
    total++; if (cap_pe[2] !== 1'b0) begin bad++; $display("FAIL stop2_parity_err got=%b want=0", cap_pe[2]); end
  endtask

  task automatic test_overrun;
    rdy[0] = 1'b0;
    send_bits(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    wait_ticks(2);
    total++; if (vld[0] !== 1'b1) begin bad++; $display("FAIL ovr_first_valid got=%b want=1", vld[0]); end
    total++; if (ovr[0] !== 1'b0) begin bad++; $display("FAIL ovr_first_flag got=%b want=0", ovr[0]); end
    send_bits(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    wait_ticks(2);
    total++; if (dout[0] !== 8'h11) begin bad++; $display("FAIL ovr_kept_data got=%h want=11", dout[0]); end
    total++; if (vld[0] !== 1'b1) begin bad++; $display("FAIL ovr_kept_valid got=%b want=1", vld[0]); end
    total++; if (ovr[0] !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b want=1", ovr[0]); end
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    total++; if (vld[0] !== 1'b0) begin bad++; $display("FAIL ovr_valid_fall got=%b want=0", vld[0]); end
    wait_ticks(20);
    total++; if (ovr[0] !== 1'b1) begin bad++; $display("FAIL ovr_sticky got=%b want=1", ovr[0]); end
  endtask

  task automatic test_reset_midframe;
    int v0;
    // Start, then bits 0..3 of 0x81; FSM is mid-DATA when reset hits.
    send_bits(0, {6'b0, 1'b1, 8'h81, 1'b0}, 5);
    reset = 1'b1;
    @(posedge clk);
    #1;
    total++; if ({vld[0], fe[0], pe[0], ovr[0]} !== 4'b0000) begin bad++; $display("FAIL midrst_flags got=%b want=0000", {vld[0], fe[0], pe[0], ovr[0]}); end
    total++; if (dout[0] !== 8'h00) begin bad++; $display("FAIL midrst_data got=%h want=00", dout[0]); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    v0 = vcyc[0];
    wait_ticks(4);
    send_bits(0, {6'b0, 1'b1, 8'h42, 1'b0}, 10);
    wait_ticks(24);
    total++; if (vcyc[0] - v0 !== 1) begin bad++; $display("FAIL midrst_count got=%0d want=1", vcyc[0] - v0); end
    total++; if (cap_d[0] !== 8'h42) begin bad++; $display("FAIL midrst_word got=%h want=42", cap_d[0]); end
    total++; if (ovr[0] !== 1'b0) begin bad++; $display("FAIL midrst_overrun got=%b want=0", ovr[0]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_stop2();
    test_overrun();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
